new_element_popup_ctrl: RTL and testbench

- Sequencer that owns the color mapper's `ScreenMode` and `NewElement` inputs, driving the "new element unlocked" full-screen popup.
- Queues unlock events from the combination logic and shows each one for a fixed number of frames, or until the player clicks.
- Switches screen mode only at frame boundaries so no frame is drawn half workspace, half popup.
- Sits between the element-combination engine, the mouse interface, the VGA controller and the color mapper.

---
 rtl/new_element_popup_ctrl.sv | 164 ++++++++++++++++
 tb/tb_new_element_popup_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/new_element_popup_ctrl.sv
// new_element_popup_ctrl: queues "element unlocked" events and sequences the
// full-screen popup shown by the color mapper. ScreenMode only changes on a
// FrameStart edge, except at reset. Each popup stays up for HOLD_FRAMES
// frames, or until the player clicks.
// Optional build macro: POPUP_DEDUP_EN -- drop an accepted index that is
// already queued or currently shown.
module new_element_popup_ctrl #(
    parameter int unsigned ELEM_W      = 10,
    parameter int unsigned MAX_ELEMENT = 720,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned HOLD_FRAMES = 180
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              FrameStart,
    input  logic              UnlockValid,
    input  logic [ELEM_W-1:0] UnlockIdx,
    output logic              UnlockReady,
    input  logic              MouseBtn,
    output logic              ScreenMode,
    output logic [ELEM_W-1:0] NewElement,
    output logic              Busy
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FRM_W = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_SHOW = 2'd2,
        S_EXIT = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ELEM_W-1:0]   fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [FRM_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                dismiss_armed_q, dismiss_armed_d;
    logic                mouse_q;
    logic                screen_mode_q, screen_mode_d;
    logic [ELEM_W-1:0]   new_elem_q, new_elem_d;

    logic idx_valid;
    logic is_dup;
    logic push;
    logic pop;
    logic click;

    // Queue handshake, pop request and qualified click detection
    assign UnlockReady = !Reset && (count_q < CNT_W'(FIFO_DEPTH));
    assign idx_valid   = (UnlockIdx != '0) && (32'(UnlockIdx) <= MAX_ELEMENT);
    assign push        = UnlockValid && UnlockReady && idx_valid && !is_dup;
    assign pop         = (state_q == S_IDLE) && (count_q != '0);
    assign click       = MouseBtn && !mouse_q && dismiss_armed_q;
    assign count_d     = count_q + CNT_W'(push) - CNT_W'(pop);

    // Duplicate detection against queued entries and the element on screen
    always_comb begin
        is_dup = 1'b0;
`ifdef POPUP_DEDUP_EN
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                (fifo_q[PTR_W'(rd_ptr_q + PTR_W'(i))] == UnlockIdx)) begin
                is_dup = 1'b1;
            end
        end
        if ((state_q != S_IDLE) && (new_elem_q == UnlockIdx)) begin
            is_dup = 1'b1;
        end
`endif
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a click takes priority over a coincident FrameStart
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (count_q != '0) state_d = S_ARM;
            S_ARM:  if (FrameStart) state_d = S_SHOW;
            S_SHOW: begin
                if (click) begin
                    state_d = S_EXIT;
                end else if (FrameStart && (frame_cnt_q == FRM_W'(1))) begin
                    state_d = S_IDLE;
                end
            end
            S_EXIT: if (FrameStart) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and frame-counter next values
    always_comb begin
        screen_mode_d   = screen_mode_q;
        new_elem_d      = new_elem_q;
        frame_cnt_d     = frame_cnt_q;
        dismiss_armed_d = dismiss_armed_q;
        case (state_q)
            S_IDLE: if (pop) new_elem_d = fifo_q[rd_ptr_q];
            S_ARM: begin
                if (FrameStart) begin
                    screen_mode_d   = 1'b1;
                    frame_cnt_d     = FRM_W'(HOLD_FRAMES);
                    dismiss_armed_d = 1'b0;
                end
            end
            S_SHOW: begin
                if (!MouseBtn) dismiss_armed_d = 1'b1;
                if (!click && FrameStart) begin
                    if (frame_cnt_q == FRM_W'(1)) begin
                        screen_mode_d = 1'b0;
                    end else begin
                        frame_cnt_d = frame_cnt_q - FRM_W'(1);
                    end
                end
            end
            S_EXIT: if (FrameStart) screen_mode_d = 1'b0;
            default: screen_mode_d = 1'b0;
        endcase
    end

    // Control and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            frame_cnt_q     <= '0;
            dismiss_armed_q <= 1'b0;
            mouse_q         <= 1'b0;
            screen_mode_q   <= 1'b0;
            new_elem_q      <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q         <= count_d;
            frame_cnt_q     <= frame_cnt_d;
            dismiss_armed_q <= dismiss_armed_d;
            mouse_q         <= MouseBtn;
            screen_mode_q   <= screen_mode_d;
            new_elem_q      <= new_elem_d;
        end
    end

    // Queue storage; contents are meaningless once the count says so
    always_ff @(posedge Clk) begin
        if (push) fifo_q[wr_ptr_q] <= UnlockIdx;
    end

    assign ScreenMode = screen_mode_q;
    assign NewElement = new_elem_q;
    assign Busy       = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_new_element_popup_ctrl.sv
// Bench for new_element_popup_ctrl: directed scenarios plus a randomized
// phase, checked every cycle against a queue-based behavioural model.
module tb_new_element_popup_ctrl;
    localparam int ELEM_W      = 10;
    localparam int MAX_ELEMENT = 720;
    localparam int FIFO_DEPTH  = 4;
    localparam int HOLD_FRAMES = 3;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              FrameStart = 1'b0;
    logic              UnlockValid = 1'b0;
    logic [ELEM_W-1:0] UnlockIdx = '0;
    logic              UnlockReady;
    logic              MouseBtn = 1'b0;
    logic              ScreenMode;
    logic [ELEM_W-1:0] NewElement;
    logic              Busy;

    always #5 Clk = ~Clk;

    new_element_popup_ctrl #(
        .ELEM_W      (ELEM_W),
        .MAX_ELEMENT (MAX_ELEMENT),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .FrameStart  (FrameStart),
        .UnlockValid (UnlockValid),
        .UnlockIdx   (UnlockIdx),
        .UnlockReady (UnlockReady),
        .MouseBtn    (MouseBtn),
        .ScreenMode  (ScreenMode),
        .NewElement  (NewElement),
        .Busy        (Busy)
    );

    int total = 0;
    int bad   = 0;

    // Model: pending list, element owned by the popup, and popup lifecycle
    int m_q[$];
    int m_shown     = 0;
    bit m_owned     = 0;
    bit m_mode      = 0;
    bit m_close     = 0;
    bit m_armed     = 0;
    bit m_prev_btn  = 0;
    int m_left      = 0;

    // Observed popup openings (element and cycle)
    int rise_elem[$];
    int rise_cyc[$];
    bit last_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit fs, input bit uv, input int ui, input bit btn);
        bit accept;
        bit valid;
        bit dup;
        if (rst) begin
            m_q.delete();
            m_shown = 0; m_owned = 0; m_mode = 0; m_close = 0;
            m_armed = 0; m_prev_btn = 0; m_left = 0;
            return;
        end
        accept = uv && (m_q.size() < FIFO_DEPTH);
        valid  = (ui >= 1) && (ui <= MAX_ELEMENT);
        dup    = 0;
`ifdef POPUP_DEDUP_EN
        foreach (m_q[i]) if (m_q[i] == ui) dup = 1;
        if (m_owned && (m_shown == ui)) dup = 1;
`endif
        if (!m_owned) begin
            if (m_q.size() > 0) begin
                m_shown = m_q.pop_front();
                m_owned = 1;
            end
        end else if (!m_mode) begin
            if (fs) begin
                m_mode  = 1;
                m_left  = HOLD_FRAMES;
                m_armed = 0;
            end
        end else if (m_close) begin
            if (fs) begin
                m_mode  = 0;
                m_owned = 0;
                m_close = 0;
            end
        end else begin
            if (btn && !m_prev_btn && m_armed) begin
                m_close = 1;
            end else if (fs) begin
                m_left--;
                if (m_left == 0) begin
                    m_mode  = 0;
                    m_owned = 0;
                end
            end
            if (!btn) m_armed = 1;
        end
        if (accept && valid && !dup) m_q.push_back(ui);
        m_prev_btn = btn;
    endtask

    task automatic compare_all();
        chk("ScreenMode", 32'(ScreenMode), 32'(m_mode));
        chk("NewElement", 32'(NewElement), m_shown);
        chk("Busy", 32'(Busy), 32'(m_owned || (m_q.size() != 0)));
        chk("UnlockReady", 32'(UnlockReady), 32'(!Reset && (m_q.size() < FIFO_DEPTH)));
    endtask

    // One clock: apply FrameStart, update model at the edge, compare after it
    task automatic step(input int k, input bit fs);
        FrameStart = fs;
        @(posedge Clk);
        model_step(Reset, fs, UnlockValid, int'(UnlockIdx), MouseBtn);
        #1;
        compare_all();
        if (ScreenMode && !last_mode) begin
            rise_elem.push_back(int'(NewElement));
            rise_cyc.push_back(k);
        end
        last_mode = ScreenMode;
    endtask

    task automatic do_reset();
        Reset = 1'b1; UnlockValid = 1'b0; UnlockIdx = '0; MouseBtn = 1'b0;
        repeat (3) step(0, 1'b0);
        Reset = 1'b0;
        #1;
        chk("rst_ready", 32'(UnlockReady), 1);
        chk("rst_mode", 32'(ScreenMode), 0);
        chk("rst_elem", 32'(NewElement), 0);
        chk("rst_busy", 32'(Busy), 0);
        rise_elem.delete();
        rise_cyc.delete();
        last_mode = 0;
    endtask

    initial begin
        int nxt;
        bit acc;
        int r;

        // Single unlock, timeout after HOLD_FRAMES boundaries
        do_reset();
        for (int k = 1; k <= 450; k++) begin
            UnlockValid = (k == 10); UnlockIdx = ELEM_W'(5);
            step(k, (k % 100) == 0);
            if (k == 10)  chk("s1_elem_before_pop", 32'(NewElement), 0);
            if (k == 11)  chk("s1_elem_after_pop", 32'(NewElement), 5);
            if (k == 99)  chk("s1_mode_99", 32'(ScreenMode), 0);
            if (k == 100) chk("s1_mode_100", 32'(ScreenMode), 1);
            if (k == 399) chk("s1_mode_399", 32'(ScreenMode), 1);
            if (k == 400) chk("s1_mode_400", 32'(ScreenMode), 0);
            if (k == 401) chk("s1_busy_401", 32'(Busy), 0);
        end

        // Click dismiss after release
        do_reset();
        for (int k = 1; k <= 450; k++) begin
            UnlockValid = (k == 10); UnlockIdx = ELEM_W'(9);
            MouseBtn = (k >= 150) && (k <= 160);
            step(k, (k % 100) == 0);
            if (k == 150) chk("s2_mode_150", 32'(ScreenMode), 1);
            if (k == 199) chk("s2_mode_199", 32'(ScreenMode), 1);
            if (k == 200) chk("s2_mode_200", 32'(ScreenMode), 0);
            if (k == 300) chk("s2_mode_300", 32'(ScreenMode), 0);
        end

        // Button held across popup appearance cannot dismiss
        do_reset();
        for (int k = 1; k <= 450; k++) begin
            UnlockValid = (k == 10); UnlockIdx = ELEM_W'(9);
            MouseBtn = (k >= 50) && (k <= 250);
            step(k, (k % 100) == 0);
            if (k == 300) chk("s2b_mode_300", 32'(ScreenMode), 1);
            if (k == 400) chk("s2b_mode_400", 32'(ScreenMode), 0);
        end

        // Queue full: six back-to-back requests
        do_reset();
        nxt = 1;
        for (int k = 1; k <= 2450; k++) begin
            UnlockValid = (k >= 10) && (nxt <= 6); UnlockIdx = ELEM_W'(nxt);
            acc = UnlockValid && (m_q.size() < FIFO_DEPTH);
            step(k, (k % 100) == 0);
            if (acc) nxt++;
            if (k == 14)  chk("s3_ready_full", 32'(UnlockReady), 0);
            if (k == 401) chk("s3_ready_after_pop", 32'(UnlockReady), 1);
        end
        chk("s3_all_accepted", nxt, 7);
        chk("s3_popup_count", rise_elem.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < rise_elem.size()) begin
                chk("s3_popup_elem", rise_elem[i], i + 1);
                chk("s3_popup_cycle", rise_cyc[i], 100 + 400 * i);
            end
        end

        // Invalid indices are accepted and dropped
        do_reset();
        for (int k = 1; k <= 250; k++) begin
            UnlockValid = (k == 10) || (k == 20);
            UnlockIdx = (k == 10) ? ELEM_W'(0) : ELEM_W'(721);
            step(k, (k % 100) == 0);
            if (k == 9)   chk("s4_ready_9", 32'(UnlockReady), 1);
            if (k == 11)  chk("s4_busy_11", 32'(Busy), 0);
            if (k == 21)  chk("s4_busy_21", 32'(Busy), 0);
            if (k == 200) chk("s4_mode_200", 32'(ScreenMode), 0);
        end
        chk("s4_no_popup", rise_elem.size(), 0);

        // Reset mid-popup with two entries queued
        do_reset();
        for (int k = 1; k <= 450; k++) begin
            UnlockValid = (k >= 10) && (k <= 12); UnlockIdx = ELEM_W'(k - 7);
            Reset = (k == 150);
            step(k, (k % 100) == 0);
            if (k == 149) chk("s5_mode_149", 32'(ScreenMode), 1);
            if (k == 150) begin
                chk("s5_mode_rst", 32'(ScreenMode), 0);
                chk("s5_elem_rst", 32'(NewElement), 0);
                chk("s5_busy_rst", 32'(Busy), 0);
                Reset = 1'b0;
                #1;
                chk("s5_ready_rst", 32'(UnlockReady), 1);
            end
            if (k == 300) chk("s5_mode_300", 32'(ScreenMode), 0);
        end
        chk("s5_one_popup", rise_elem.size(), 1);

        // Duplicate requests while popup 7 is showing
        do_reset();
        for (int k = 1; k <= 1250; k++) begin
            UnlockValid = (k == 10) || (k == 150) || (k == 151);
            UnlockIdx = (k == 151) ? ELEM_W'(8) : ELEM_W'(7);
            step(k, (k % 100) == 0);
        end
`ifdef POPUP_DEDUP_EN
        chk("s6_popup_count", rise_elem.size(), 2);
        if (rise_elem.size() >= 2) begin
            chk("s6_first", rise_elem[0], 7);
            chk("s6_second", rise_elem[1], 8);
        end
`else
        chk("s6_popup_count", rise_elem.size(), 3);
        if (rise_elem.size() >= 3) begin
            chk("s6_first", rise_elem[0], 7);
            chk("s6_second", rise_elem[1], 7);
            chk("s6_third", rise_elem[2], 8);
        end
`endif

        // Randomized traffic with random frame pulses, clicks and resets
        do_reset();
        for (int k = 1; k <= 4000; k++) begin
            Reset = ($urandom_range(0, 599) == 0);
            UnlockValid = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 15));
            if (r < 12)       UnlockIdx = ELEM_W'(r);
            else if (r == 12) UnlockIdx = ELEM_W'(721);
            else              UnlockIdx = ELEM_W'($urandom_range(0, 1023));
            if ($urandom_range(0, 5) == 0) MouseBtn = !MouseBtn;
            step(k, $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
